aes_iter_core: RTL

Parametrised iterative AES encryption engine, successor to the fixed AES-128 core. It supports AES-128 or AES-256 at elaboration time and executes one full cipher round per clock. Round keys are generated on the fly from a rolling key-schedule window, so no 44/60-word key array is stored. It sits between the SPI shift-register front end and the result register, with the same load/done handshake.

---
 rtl/aes_pkg.sv | 61 ++++++
 rtl/aes_iter_core_if.sv | 22 ++
 rtl/aes_key_step.sv | 37 +++
 rtl/aes_iter_core.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, GF(2^8) helpers, round constants,
// round-count helper and the controller state encoding.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_fsm_e;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Byte b sits at bits [2047-8b -: 8], i.e. {~b, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Out-of-range indices (idle cycles) yield zero.
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        return (idx < 4'd10) ? RCON[idx] : 8'h00;
    endfunction

    function automatic int nr_of(input int kb);
        return (kb == 256) ? 14 : 10;
    endfunction

endpackage

// File: rtl/aes_iter_core_if.sv
// Load/done handshake bundle between the SPI front end, the cipher core
// and the result register.
interface aes_iter_core_if #(
    parameter int KEY_BITS = 128
);
    logic                load;
    logic [KEY_BITS-1:0] key;
    logic [127:0]        plaintext;
    logic                busy;
    logic                done;
    logic [127:0]        cyphertext;

    modport master (
        output load, key, plaintext,
        input  busy, done, cyphertext
    );

    modport slave (
        input  load, key, plaintext,
        output busy, done, cyphertext
    );
endinterface

// File: rtl/aes_key_step.sv
// One step of the on-the-fly key expansion: from the current window of
// NK schedule words produce the next four words.
module aes_key_step
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic [KEY_BITS-1:0] i_win,
    input  logic                i_rot_en,
    input  logic [7:0]          i_rcon,
    output logic [127:0]        o_next
);

    logic [31:0] w_tail;
    logic [31:0] w_sub_in;
    logic [31:0] w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;
    // Middle words of an AES-256 window do not feed this step.
    logic        w_unused;

    assign w_unused = ^i_win;

    // Transform the newest word, then chain XORs against the oldest words.
    always_comb begin
        w_tail   = i_win[31:0];
        w_sub_in = i_rot_en ? {w_tail[23:0], w_tail[31:24]} : w_tail;
        w_temp   = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                    sbox(w_sub_in[15:8]),  sbox(w_sub_in[7:0])}
                 ^ (i_rot_en ? {i_rcon, 24'h000000} : 32'h00000000);
        w_n0     = i_win[KEY_BITS-1  -: 32] ^ w_temp;
        w_n1     = i_win[KEY_BITS-33 -: 32] ^ w_n0;
        w_n2     = i_win[KEY_BITS-65 -: 32] ^ w_n1;
        w_n3     = i_win[KEY_BITS-97 -: 32] ^ w_n2;
        o_next   = {w_n0, w_n1, w_n2, w_n3};
    end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryption core, one round per clock, round keys
// generated on the fly from a rolling schedule window.
// Optional build macro: AES_ITER_CLR_OUT_EN clears cyphertext while a
// block is in flight instead of holding the previous result.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic           clk,
    input  logic           rst,
    aes_iter_core_if.slave bus
);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end

    localparam int         NR   = nr_of(KEY_BITS);
    localparam logic [3:0] NR_L = 4'(NR);

    aes_fsm_e            r_fsm, w_fsm_nxt;
    logic [3:0]          r_round;
    logic [127:0]        r_state;
    logic [127:0]        r_ct;
    logic [KEY_BITS-1:0] r_win;
    logic [KEY_BITS-1:0] w_win_nxt;

    logic                w_start, w_run, w_last;
    logic                w_rot_en;
    logic [3:0]          w_rc_idx;
    logic [7:0]          w_rcon;
    logic [127:0]        w_kstep, w_rk;
    logic [127:0]        w_sb, w_sr, w_mc, w_round;

    assign w_start = bus.load && (r_fsm != ST_RUN);
    assign w_run   = (r_fsm == ST_RUN);
    assign w_last  = w_run && (r_round == NR_L);

    // AES-128 window is the previous round key; AES-256 window is the last
    // eight words, with round 1 taking the second key half untouched.
    if (KEY_BITS == 128) begin : g_k128
        assign w_rot_en  = 1'b1;
        assign w_rc_idx  = r_round - 4'd1;
        assign w_rk      = w_kstep;
        assign w_win_nxt = w_kstep;
    end else begin : g_k256
        assign w_rot_en  = ~r_round[0];
        assign w_rc_idx  = {1'b0, r_round[3:1]} - 4'd1;
        assign w_rk      = (r_round == 4'd1) ? r_win[127:0] : w_kstep;
        assign w_win_nxt = (r_round == 4'd1) ? r_win : {r_win[127:0], w_kstep};
    end

    assign w_rcon = rcon_of(w_rc_idx);

    aes_key_step #(
        .KEY_BITS (KEY_BITS)
    ) u_key_step (
        .i_win    (r_win),
        .i_rot_en (w_rot_en),
        .i_rcon   (w_rcon),
        .o_next   (w_kstep)
    );

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3,
                a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3,
                a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3),
                gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3)};
    endfunction

    // One cipher round; byte n (row n%4, column n/4) lives at [127-8n -: 8].
    always_comb begin
        w_sb = '0;
        w_sr = '0;
        w_mc = '0;
        for (int n = 0; n < 16; n++) begin
            w_sb[8*n +: 8] = sbox(r_state[8*n +: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                w_sr[8*(15-(4*c+rw)) +: 8] = w_sb[8*(15-(4*((c+rw)%4)+rw)) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mc[32*(3-c) +: 32] = mix_column(w_sr[32*(3-c) +: 32]);
        end
        w_round = (w_last ? w_sr : w_mc) ^ w_rk;
    end

    // Controller next state: accept a block from IDLE/DONE, finish after NR.
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            ST_IDLE: if (bus.load) w_fsm_nxt = ST_RUN;
            ST_RUN:  if (r_round == NR_L) w_fsm_nxt = ST_DONE;
            ST_DONE: if (bus.load) w_fsm_nxt = ST_RUN;
            default: w_fsm_nxt = ST_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) r_fsm <= ST_IDLE;
        else     r_fsm <= w_fsm_nxt;
    end

    // Round counter: 1 on accept, advances per round, clears entering DONE.
    always_ff @(posedge clk) begin
        if (rst)          r_round <= '0;
        else if (w_start) r_round <= 4'd1;
        else if (w_last)  r_round <= '0;
        else if (w_run)   r_round <= r_round + 4'd1;
    end

    // Cipher state and key window; contents are don't-care outside RUN.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_state <= bus.plaintext ^ bus.key[KEY_BITS-1 -: 128];
            r_win   <= bus.key;
        end else if (w_run) begin
            r_state <= w_round;
            r_win   <= w_win_nxt;
        end
    end

    // Result register, written with the final round output.
    always_ff @(posedge clk) begin
        if (rst)         r_ct <= '0;
        else if (w_last) r_ct <= w_round;
`ifdef AES_ITER_CLR_OUT_EN
        else if (w_start) r_ct <= '0;
`endif
    end

    assign bus.busy       = (r_fsm == ST_RUN);
    assign bus.done       = (r_fsm == ST_DONE);
    assign bus.cyphertext = r_ct;

endmodule
